// File: rtl/seg_argmax.sv
// seg_argmax: per-pixel argmax classification head with a per-frame class histogram.
//   clock, rst        : system clock, asynchronous active-high reset
//   in_feat           : UNITS signed Q(INT_BITW).(FRAC_BITW) features, unit k at [k*FIXED_BITW +: FIXED_BITW]
//   in_vcnt, in_hcnt  : scan coordinates of in_feat
//   out_label         : index of the largest feature (lowest index wins ties)
//   out_conf          : largest feature clamped to [0, 2^UINT_BITW-1]
//   out_vcnt/out_hcnt : input coordinates delayed by LATENCY
//   hist, hist_valid  : last completed frame's per-class pixel counts and its update pulse
module seg_argmax #(
    parameter int HEIGHT    = -1,
    parameter int WIDTH     = -1,
    parameter int W_HEIGHT  = -1,
    parameter int W_WIDTH   = -1,
    parameter int UNITS     = 12,
    parameter int INT_BITW  = 5,
    parameter int FRAC_BITW = 8,
    parameter int UINT_BITW = 8,
    localparam int unsigned FIXED_BITW = INT_BITW + FRAC_BITW,
    localparam int unsigned LBL_BITW   = $clog2(UNITS),
    localparam int unsigned V_BITW     = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1,
    localparam int unsigned H_BITW     = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1,
    localparam int unsigned CNT_BITW   = (HEIGHT * WIDTH > 0) ? $clog2(HEIGHT * WIDTH + 1) : 1,
    localparam int unsigned LATENCY    = LBL_BITW + 2
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic [0:FIXED_BITW*UNITS-1]      in_feat,
    input  logic [V_BITW-1:0]                in_vcnt,
    input  logic [H_BITW-1:0]                in_hcnt,
    output logic [LBL_BITW-1:0]              out_label,
    output logic [UINT_BITW-1:0]             out_conf,
    output logic [V_BITW-1:0]                out_vcnt,
    output logic [H_BITW-1:0]                out_hcnt,
    output logic [0:CNT_BITW*UNITS-1]        hist,
    output logic                             hist_valid
);

    typedef enum logic {
        UNSYNCED = 1'b0,
        COUNTING = 1'b1
    } state_t;

    // Number of live (value, index) pairs at a given tree level.
    function automatic int unsigned level_nodes(input int unsigned lvl);
        int unsigned n;
        n = UNITS;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    logic signed [FIXED_BITW-1:0] tree_val [LBL_BITW+1][UNITS];
    logic        [LBL_BITW-1:0]   tree_idx [LBL_BITW+1][UNITS];
    logic        [V_BITW-1:0]     vcnt_pipe [LATENCY];
    logic        [H_BITW-1:0]     hcnt_pipe [LATENCY];
    logic        [LATENCY-1:0]    valid_pipe;
    logic                         out_valid_int;

    logic signed [FIXED_BITW-1:0] max_val;
    logic        [UINT_BITW-1:0]  conf_sat;

    state_t                       state;
    logic        [CNT_BITW-1:0]   acc     [UNITS];
    logic        [CNT_BITW-1:0]   acc_nxt [UNITS];
    logic                         sync_hit;
    logic                         frame_end;
    logic                         active_px;
    logic                         count_en;

    // Level 0 captures the inputs; levels 1..LBL_BITW reduce pairwise, left operand wins ties.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int l = 0; l <= int'(LBL_BITW); l++) begin
                for (int j = 0; j < UNITS; j++) begin
                    tree_val[l][j] <= '0;
                    tree_idx[l][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < UNITS; k++) begin
                tree_val[0][k] <= in_feat[k*FIXED_BITW +: FIXED_BITW];
                tree_idx[0][k] <= LBL_BITW'(k);
            end
            for (int l = 1; l <= int'(LBL_BITW); l++) begin
                for (int j = 0; j < UNITS; j++) begin
                    tree_val[l][j] <= '0;
                    tree_idx[l][j] <= '0;
                end
                for (int j = 0; j < UNITS / 2; j++) begin
                    if (2 * j + 1 < int'(level_nodes(l - 1))) begin
                        if (tree_val[l-1][2*j+1] > tree_val[l-1][2*j]) begin
                            tree_val[l][j] <= tree_val[l-1][2*j+1];
                            tree_idx[l][j] <= tree_idx[l-1][2*j+1];
                        end else begin
                            tree_val[l][j] <= tree_val[l-1][2*j];
                            tree_idx[l][j] <= tree_idx[l-1][2*j];
                        end
                    end
                end
                // Odd leftover at this level passes through unchanged.
                if (level_nodes(l - 1) % 2 == 1) begin
                    tree_val[l][level_nodes(l-1)/2] <= tree_val[l-1][level_nodes(l-1)-1];
                    tree_idx[l][level_nodes(l-1)/2] <= tree_idx[l-1][level_nodes(l-1)-1];
                end
            end
        end
    end

    // Clamp the winning value: negative -> 0, any integer part -> full scale, else the fraction.
    always_comb begin
        max_val  = tree_val[LBL_BITW][0];
        conf_sat = UINT_BITW'(max_val[FRAC_BITW-1:0]);
        if (max_val[FIXED_BITW-1]) begin
            conf_sat = '0;
        end else if (|max_val[FIXED_BITW-2:FRAC_BITW]) begin
            conf_sat = '1;
        end
    end

    // Final stage plus the coordinate / valid delay line.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_label  <= '0;
            out_conf   <= '0;
            valid_pipe <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                vcnt_pipe[i] <= '0;
                hcnt_pipe[i] <= '0;
            end
        end else begin
            out_label    <= tree_idx[LBL_BITW][0];
            out_conf     <= conf_sat;
            valid_pipe   <= {valid_pipe[LATENCY-2:0], 1'b1};
            vcnt_pipe[0] <= in_vcnt;
            hcnt_pipe[0] <= in_hcnt;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vcnt_pipe[i] <= vcnt_pipe[i-1];
                hcnt_pipe[i] <= hcnt_pipe[i-1];
            end
        end
    end

    assign out_vcnt      = vcnt_pipe[LATENCY-1];
    assign out_hcnt      = hcnt_pipe[LATENCY-1];
    assign out_valid_int = valid_pipe[LATENCY-1];

    // Extra MSB on the bound compares keeps a power-of-two HEIGHT/WIDTH from truncating to 0.
    assign sync_hit  = out_valid_int && (out_vcnt == '0) && (out_hcnt == '0);
    assign frame_end = (out_vcnt == V_BITW'(W_HEIGHT - 1)) && (out_hcnt == H_BITW'(W_WIDTH - 1));
    assign active_px = out_valid_int
                    && ({1'b0, out_vcnt} < (V_BITW + 1)'(HEIGHT))
                    && ({1'b0, out_hcnt} < (H_BITW + 1)'(WIDTH))
                    && ({1'b0, out_label} < (LBL_BITW + 1)'(UNITS));
    assign count_en  = (state == COUNTING) || sync_hit;

    // Accumulators with this cycle's saturating increment applied.
    always_comb begin
        for (int k = 0; k < UNITS; k++) begin
            acc_nxt[k] = acc[k];
        end
        if (count_en && active_px && (acc[out_label] != '1)) begin
            acc_nxt[out_label] = acc[out_label] + 1'b1;
        end
    end

    // Histogram FSM: sync on the first (0,0), publish and clear at each frame end.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= UNSYNCED;
            hist       <= '0;
            hist_valid <= 1'b0;
            for (int k = 0; k < UNITS; k++) begin
                acc[k] <= '0;
            end
        end else begin
            hist_valid <= 1'b0;
            case (state)
                UNSYNCED: begin
                    if (sync_hit) begin
                        state <= COUNTING;
                        acc   <= acc_nxt;
                    end
                end
                COUNTING: begin
                    if (frame_end) begin
                        for (int k = 0; k < UNITS; k++) begin
                            hist[k*CNT_BITW +: CNT_BITW] <= acc_nxt[k];
                            acc[k]                       <= '0;
                        end
                        hist_valid <= 1'b1;
                    end else begin
                        acc <= acc_nxt;
                    end
                end
                default: state <= UNSYNCED;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_argmax.sv
// tb_seg_argmax: randomized and directed stimulus for seg_argmax, checked against a
// transaction-level reference (argmax over an array, clamp, and a frame-histogram model).
module tb_seg_argmax;

    localparam int HEIGHT   = 4;
    localparam int WIDTH    = 4;
    localparam int W_HEIGHT = 6;
    localparam int W_WIDTH  = 6;
    localparam int UNITS    = 12;
    localparam int FB       = 13;
    localparam int LB       = 4;
    localparam int VB       = 3;
    localparam int HB       = 3;
    localparam int CB       = 5;
    localparam int LAT      = 6;
    localparam int CNT_MAX  = (1 << CB) - 1;

    logic                  clock;
    logic                  rst;
    logic [0:FB*UNITS-1]   in_feat;
    logic [VB-1:0]         in_vcnt;
    logic [HB-1:0]         in_hcnt;
    logic [LB-1:0]         out_label;
    logic [7:0]            out_conf;
    logic [VB-1:0]         out_vcnt;
    logic [HB-1:0]         out_hcnt;
    logic [0:CB*UNITS-1]   hist;
    logic                  hist_valid;

    seg_argmax #(
        .HEIGHT(HEIGHT), .WIDTH(WIDTH), .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH),
        .UNITS(UNITS), .INT_BITW(5), .FRAC_BITW(8), .UINT_BITW(8)
    ) dut (
        .clock(clock), .rst(rst), .in_feat(in_feat), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_label(out_label), .out_conf(out_conf), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
        .hist(hist), .hist_valid(hist_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit vld;
        int lbl;
        int conf;
        int v;
        int h;
    } exp_t;

    exp_t q[$];
    int   fv[UNITS];
    int   acc_m[UNITS];
    int   hist_m[UNITS];
    bit   hv_m;
    bit   synced_m;
    int   sv, sh;
    int   n_chk, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] hist_model_packed();
        logic [0:CB*UNITS-1] hm;
        for (int k = 0; k < UNITS; k++) hm[k*CB +: CB] = CB'(hist_m[k]);
        return {4'h0, hm};
    endfunction

    // Drive fv and the current raster position, queue the expected result, advance raster.
    task automatic apply();
        exp_t e;
        int best;
        best = 0;
        for (int k = 1; k < UNITS; k++) if (fv[k] > fv[best]) best = k;
        e.vld  = 1'b1;
        e.lbl  = best;
        e.conf = (fv[best] < 0) ? 0 : (fv[best] >= 256) ? 255 : fv[best];
        e.v    = sv;
        e.h    = sh;
        q.push_back(e);
        for (int k = 0; k < UNITS; k++) in_feat[k*FB +: FB] = FB'(fv[k]);
        in_vcnt = VB'(sv);
        in_hcnt = HB'(sh);
        sh++;
        if (sh == W_WIDTH) begin
            sh = 0;
            sv = (sv + 1) % W_HEIGHT;
        end
    endtask

    task automatic model_hist(input exp_t e);
        if (!synced_m && e.v == 0 && e.h == 0) synced_m = 1'b1;
        if (synced_m) begin
            if (e.v < HEIGHT && e.h < WIDTH && acc_m[e.lbl] < CNT_MAX) acc_m[e.lbl]++;
            if (e.v == W_HEIGHT - 1 && e.h == W_WIDTH - 1) begin
                for (int k = 0; k < UNITS; k++) begin
                    hist_m[k] = acc_m[k];
                    acc_m[k]  = 0;
                end
                hv_m = 1'b1;
            end
        end
    endtask

    // One clock: check outputs against the oldest queued expectation, then feed fv.
    task automatic feed();
        exp_t e;
        @(posedge clock);
        #1;
        e = q.pop_front();
        chk("label", 64'(out_label), 64'(e.lbl));
        chk("conf",  64'(out_conf),  64'(e.conf));
        chk("vcnt",  64'(out_vcnt),  64'(e.v));
        chk("hcnt",  64'(out_hcnt),  64'(e.h));
        chk("hist",  {4'h0, hist},   hist_model_packed());
        chk("hist_valid", 64'(hist_valid), 64'(hv_m));
        hv_m = 1'b0;
        if (e.vld) model_hist(e);
        apply();
    endtask

    task automatic do_reset(input int n);
        exp_t z;
        @(posedge clock);
        #1;
        rst = 1'b1;
        q.delete();
        z.vld = 1'b0; z.lbl = 0; z.conf = 0; z.v = 0; z.h = 0;
        repeat (LAT - 1) q.push_back(z);
        for (int k = 0; k < UNITS; k++) begin
            acc_m[k]  = 0;
            hist_m[k] = 0;
        end
        hv_m     = 1'b0;
        synced_m = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
            chk("rst_label", 64'(out_label), 64'd0);
            chk("rst_conf",  64'(out_conf),  64'd0);
            chk("rst_vcnt",  64'(out_vcnt),  64'd0);
            chk("rst_hist",  {4'h0, hist},   64'd0);
            chk("rst_hist_valid", 64'(hist_valid), 64'd0);
        end
        rst = 1'b0;
        apply();
    endtask

    task automatic set_all(input int val);
        for (int k = 0; k < UNITS; k++) fv[k] = val;
    endtask

    // Random negatives everywhere, a non-negative value at cls so it wins outright.
    task automatic set_win(input int cls);
        for (int k = 0; k < UNITS; k++) fv[k] = int'($urandom_range(0, 4095)) - 4096;
        fv[cls] = int'($urandom_range(0, 511));
    endtask

    task automatic set_rand();
        for (int k = 0; k < UNITS; k++) begin
            if ($urandom_range(0, 3) == 0) fv[k] = int'($urandom_range(0, 3)) * 64 - 64;
            else                           fv[k] = int'($urandom_range(0, 8191)) - 4096;
        end
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        in_feat = '0;
        in_vcnt = '0;
        in_hcnt = '0;
        sv      = 0;
        sh      = 0;
        set_all(0);

        do_reset(3);

        // Single clear winner with an integer part: label 5, saturated confidence.
        set_all(-256); fv[5] = 384; feed();
        set_all(0); repeat (LAT) feed();

        // Equal maxima resolve to the lower index; all-negative gives zero confidence.
        set_all(-256); fv[3] = 64; fv[7] = 64; feed();
        set_all(-256); fv[11] = -1; feed();

        // Clamp edges around 2^FRAC.
        set_all(-256); fv[0] = 255; feed();
        set_all(-256); fv[9] = 256; feed();
        set_all(-256); fv[4] = 128; feed();

        // Back-to-back stream with the winner cycling through every class.
        for (int i = 0; i < 24; i++) begin
            set_win(i % UNITS);
            feed();
        end

        // Fully random vectors, including frequent ties.
        for (int i = 0; i < 60; i++) begin
            set_rand();
            feed();
        end

        // Frames: start mid-frame after reset, then full frames with a known class map.
        sv = 2; sh = 1;
        set_win(0);
        do_reset(2);
        for (int i = 0; i < 23 + 3 * 36; i++) begin
            if (sv < HEIGHT && sh < WIDTH) set_win((sv * 4 + sh) % UNITS);
            else                           set_win(int'($urandom_range(0, UNITS - 1)));
            feed();
        end

        // Reset mid-frame, resync on the next (0,0), then two more frames.
        sv = 1; sh = 3;
        do_reset(3);
        for (int i = 0; i < 2 * 36 + 20; i++) begin
            if (sv < HEIGHT && sh < WIDTH) set_win((sv * 4 + sh) % UNITS);
            else                           set_win(int'($urandom_range(0, UNITS - 1)));
            feed();
        end

        // Coordinate jumps back to (0,0) without a frame end keep counting until saturation.
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < HEIGHT; v++) begin
                for (int h = 0; h < WIDTH; h++) begin
                    sv = v; sh = h;
                    set_win(2);
                    feed();
                end
            end
        end
        sv = W_HEIGHT - 1; sh = W_WIDTH - 1;
        set_win(7);
        feed();

        for (int i = 0; i < LAT + 4; i++) begin
            set_rand();
            feed();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seg_argmax.md
Name: seg_argmax

Overview:
- Per-pixel classification head directly downstream of the 3-layer feature-extraction CNN.
- Consumes the 12-unit signed fixed-point feature vector plus its vcnt/hcnt stream.
- Emits per pixel: the winning class label, a uint8 confidence, and delayed coordinates.
- Accumulates a per-class pixel histogram over each frame's active area and publishes it once per frame.

Parameters:
- HEIGHT, -1, active image height
- WIDTH, -1, active image width
- W_HEIGHT, -1, total scan height including blanking
- W_WIDTH, -1, total scan width including blanking
- UNITS, 12, number of feature channels / classes
- INT_BITW, 5, integer bits of each feature, sign included
- FRAC_BITW, 8, fractional bits; must equal UINT_BITW
- UINT_BITW, 8, confidence output width

Derived localparams:
- FIXED_BITW = INT_BITW+FRAC_BITW
- LBL_BITW = ceil(log2(UNITS))
- V_BITW = ceil(log2(W_HEIGHT)), H_BITW = ceil(log2(W_WIDTH))
- CNT_BITW = ceil(log2(HEIGHT*WIDTH+1))
- LATENCY = LBL_BITW+2

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_feat  in  [0:FIXED_BITW*UNITS-1]  unit k at bits [k*FIXED_BITW +: FIXED_BITW], two's complement
- in_vcnt  in  V_BITW  row of in_feat
- in_hcnt  in  H_BITW  column of in_feat
- out_label  out  LBL_BITW  argmax class index
- out_conf  out  UINT_BITW  saturated max feature value
- out_vcnt  out  V_BITW  in_vcnt delayed by LATENCY
- out_hcnt  out  H_BITW  in_hcnt delayed by LATENCY
- hist  out  [0:CNT_BITW*UNITS-1]  last completed frame's per-class counts, class k at [k*CNT_BITW +: CNT_BITW]
- hist_valid  out  1  one-cycle pulse when hist updates

Behaviour:
- Reset (async, rst=1): every pipeline register, out_*, hist, hist_valid, the valid pipe, the accumulators and the FSM go to 0 / UNSYNCED.
- Input takes a new vector every cycle; there is no stall.
- Stage 0 registers in_feat and the coordinates.
- Stages 1..LBL_BITW form a registered pairwise compare tree carrying (value, index) pairs.
- Odd leftovers at any tree level pass through registered, unchanged.
- Comparison is signed.
- Ties go to the lower index: the right operand wins only if strictly greater.
- Final stage computes out_conf from max value m:
  - m<0 gives 0.
  - m >= 2^FRAC_BITW gives 2^UINT_BITW-1.
  - Otherwise out_conf = m[FRAC_BITW-1:0].
- Coordinates travel through a LATENCY-deep delay line; a 1-bit valid pipe travels with them.
- Valid pipe is 0 out of reset, 1 shifted in every cycle; out_valid_int = last bit.
- Total latency is exactly LATENCY cycles: in_feat at cycle t appears on out_label/out_conf/out_vcnt/out_hcnt at cycle t+LATENCY.
  - For UNITS=12 this is 6 cycles.
- Histogram FSM, UNSYNCED:
  - Counting is disabled.
  - Move to COUNTING when out_valid_int and out_vcnt==0 and out_hcnt==0. The (0,0) pixel is counted in that same cycle.
- Histogram FSM, COUNTING:
  - Active pixel = out_valid_int and out_vcnt<HEIGHT and out_hcnt<WIDTH.
  - For an active pixel, acc[out_label] increments by 1, saturating at 2^CNT_BITW-1.
- Frame end, i.e. COUNTING and out_vcnt==W_HEIGHT-1 and out_hcnt==W_WIDTH-1:
  - hist gets acc, including any increment from this same cycle.
  - All acc clear to 0.
  - hist_valid=1 for that cycle only.
  - FSM stays COUNTING.
- A frame end never occurs in UNSYNCED. The partial first frame after reset therefore never publishes.
- Coordinate jump: if out coords ever return to (0,0) before a frame end, accumulators are NOT cleared; the count continues. Only the frame-end position publishes.
- Reset mid-frame: everything returns to UNSYNCED, and hist reads 0 until the next complete frame.
- hist holds its value between pulses.

Test Plan:
Bench parameters for all scenarios: HEIGHT=4, WIDTH=4, W_HEIGHT=6, W_WIDTH=6, UNITS=12.
- Reset release, then feed vector with unit5=+1.5 (384) and all others -1 at t0 -> at t0+6: out_label=5, out_conf=255, out_vcnt/out_hcnt equal t0's inputs. Before t0+6 out_label=0.
- Ties: units 3 and 7 both 0x40, others -256 -> out_label=3, out_conf=64. All units negative with max at unit 11 = -1 -> out_label=11, out_conf=0.
- Streaming: a new vector every cycle with label cycling 0..11 -> out_label sequence identical, delayed 6 cycles, no bubbles.
- Frames: start mid-frame after reset, then 2 full frames where active pixel (v,h) has max at class (v*4+h)%12:
  - No hist_valid at the first frame end.
  - Then hist_valid pulses once per frame.
  - Counts are classes 0-3 =2, classes 4-11 =1.
  - Blanking pixels are not counted.
- Assert rst for 3 cycles mid-frame -> hist=0 and hist_valid=0 until the first frame end following a (0,0) resync; the published counts equal a clean frame.
- Saturation: single-feature value 0x0FF -> out_conf=255. Value 0x100 -> 255. Value 0x080 -> 128.
